// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and the logic-unit opcode encoding.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NAND  = 3'b011,
        OP_NOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOTA  = 3'b110,  // b ignored
        OP_PASSB = 3'b111   // a ignored
    } logic_op_t;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise logic core with result flags.
// Ports:
//   a, b    : operands (WIDTH bits)
//   op      : operation select (alu_pkg::logic_op_t)
//   s       : result
//   zero    : s == 0
//   msb     : s[WIDTH-1]
//   parity  : XOR-reduce of s (1 = odd ones count)
//   popcnt  : number of ones in s (only when LOGIC_UNIT_POPCOUNT_EN is defined)
module logic_op_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic_op_t                    op,
    output logic [WIDTH-1:0]             s,
    output logic                         zero,
`ifdef LOGIC_UNIT_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0]   popcnt,
`endif
    output logic                         msb,
    output logic                         parity
);

    always_comb begin
        s = '0;
        unique case (op)
            OP_AND:   s = a & b;
            OP_OR:    s = a | b;
            OP_XOR:   s = a ^ b;
            OP_NAND:  s = ~(a & b);
            OP_NOR:   s = ~(a | b);
            OP_XNOR:  s = ~(a ^ b);
            OP_NOTA:  s = ~a;
            OP_PASSB: s = b;
            default:  s = '0;
        endcase
    end

    assign zero   = (s == '0);
    assign msb    = s[WIDTH-1];
    assign parity = ^s;

`ifdef LOGIC_UNIT_POPCOUNT_EN
    localparam int unsigned PC_W = $clog2(WIDTH+1);

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            popcnt = popcnt + PC_W'(s[i]);
        end
    end
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides.
// Stage 1 captures operands on a transfer; stage 2 registers result and flags.
// Optional feature: define LOGIC_UNIT_POPCOUNT_EN to add out_popcnt.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_a, in_b, in_op    : operands and opcode
//   out_valid/out_ready  : output handshake
//   out_s                : result
//   out_zero/msb/parity  : flags of out_s, registered with it
//   out_popcnt           : ones count of out_s (LOGIC_UNIT_POPCOUNT_EN only)
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OP_W  = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [OP_W-1:0]              in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_s,
    output logic                         out_zero,
    output logic                         out_msb,
`ifdef LOGIC_UNIT_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0]   out_popcnt,
`endif
    output logic                         out_parity
);

    import alu_pkg::*;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic_op_t        s1_op_q, s1_op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_s_q, out_s_d;
    logic             out_zero_q, out_zero_d;
    logic             out_msb_q, out_msb_d;
    logic             out_parity_q, out_parity_d;

    logic [WIDTH-1:0] core_s;
    logic             core_zero, core_msb, core_parity;
    logic             s2_ready;

`ifdef LOGIC_UNIT_POPCOUNT_EN
    localparam int unsigned PC_W = $clog2(WIDTH+1);
    logic [PC_W-1:0] core_popcnt;
    logic [PC_W-1:0] out_popcnt_q, out_popcnt_d;
`endif

    // Ready depends only on registered state and out_ready.
    assign s2_ready = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_ready;

    logic_op_core #(
        .WIDTH  (WIDTH)
    ) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .s      (core_s),
        .zero   (core_zero),
`ifdef LOGIC_UNIT_POPCOUNT_EN
        .popcnt (core_popcnt),
`endif
        .msb    (core_msb),
        .parity (core_parity)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        out_valid_d  = out_valid_q;
        out_s_d      = out_s_q;
        out_zero_d   = out_zero_q;
        out_msb_d    = out_msb_q;
        out_parity_d = out_parity_q;
`ifdef LOGIC_UNIT_POPCOUNT_EN
        out_popcnt_d = out_popcnt_q;
`endif

        // in_ready means stage 1 is empty or drains this cycle.
        if (in_ready) begin
            s1_valid_d = in_valid;
            // Operands only load on a transfer, so an idle in_op is never used.
            if (in_valid) begin
                s1_a_d  = in_a;
                s1_b_d  = in_b;
                s1_op_d = logic_op_t'(in_op);
            end
        end

        // On a bubble out_valid drops but out_s and the flags keep their value.
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_s_d      = core_s;
                out_zero_d   = core_zero;
                out_msb_d    = core_msb;
                out_parity_d = core_parity;
`ifdef LOGIC_UNIT_POPCOUNT_EN
                out_popcnt_d = core_popcnt;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= OP_AND;
            out_valid_q  <= 1'b0;
            out_s_q      <= '0;
            out_zero_q   <= 1'b0;
            out_msb_q    <= 1'b0;
            out_parity_q <= 1'b0;
`ifdef LOGIC_UNIT_POPCOUNT_EN
            out_popcnt_q <= '0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            out_valid_q  <= out_valid_d;
            out_s_q      <= out_s_d;
            out_zero_q   <= out_zero_d;
            out_msb_q    <= out_msb_d;
            out_parity_q <= out_parity_d;
`ifdef LOGIC_UNIT_POPCOUNT_EN
            out_popcnt_q <= out_popcnt_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_s      = out_s_q;
    assign out_zero   = out_zero_q;
    assign out_msb    = out_msb_q;
    assign out_parity = out_parity_q;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    assign out_popcnt = out_popcnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: WIDTH=16 main instance with a scoreboard queue,
// plus a WIDTH=8 instance for the narrow-width case.
module tb_logic_unit_pipe;

    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_s;
    logic        out_zero, out_msb, out_parity;
    logic [4:0]  out_popcnt;

    logic        v8 = 1'b0;
    logic        rdy8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [2:0]  op8 = '0;
    logic        ov8;
    logic [7:0]  s8;
    logic        z8, m8, p8;
    logic [3:0]  pc8;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16), .OP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_zero   (out_zero),
        .out_msb    (out_msb),
`ifdef LOGIC_UNIT_POPCOUNT_EN
        .out_popcnt (out_popcnt),
`endif
        .out_parity (out_parity)
    );

    logic_unit_pipe #(.WIDTH(8), .OP_W(3)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v8),
        .in_ready   (rdy8),
        .in_a       (a8),
        .in_b       (b8),
        .in_op      (op8),
        .out_valid  (ov8),
        .out_ready  (1'b1),
        .out_s      (s8),
        .out_zero   (z8),
        .out_msb    (m8),
`ifdef LOGIC_UNIT_POPCOUNT_EN
        .out_popcnt (pc8),
`endif
        .out_parity (p8)
    );

`ifndef LOGIC_UNIT_POPCOUNT_EN
    assign out_popcnt = '0;
    assign pc8 = '0;
`endif

    typedef struct packed {
        logic [15:0] s;
        logic        z;
        logic        m;
        logic        p;
        logic [4:0]  pc;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Flags for the non-table beats, derived from the expected result value.
    function automatic exp_t mk(input logic [15:0] s);
        exp_t e;
        e.s  = s;
        e.z  = (s == 16'h0);
        e.m  = s[15];
        e.p  = ^s;
        e.pc = 5'($countones(s));
        return e;
    endfunction

    // Output monitor: every accepted result is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(out_s), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_s", 32'(out_s), 32'(e.s));
                chk("out_zero", 32'(out_zero), 32'(e.z));
                chk("out_msb", 32'(out_msb), 32'(e.m));
                chk("out_parity", 32'(out_parity), 32'(e.p));
`ifdef LOGIC_UNIT_POPCOUNT_EN
                chk("out_popcnt", 32'(out_popcnt), 32'(e.pc));
`endif
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat transfers.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input exp_t e);
        int waits = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                break;
            end
            waits++;
            stall_cnt++;
            if (waits > 50) begin
                chk("send_timeout", 32'd1, 32'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op = 3'bxxx;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        chk(name, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[11];
    vec_t bp[4];

    initial begin
        int acc;
        logic saw;

        tbl[0]  = '{16'hF0F0, 16'hFF00, OP_AND,   '{16'hF000, 1'b0, 1'b1, 1'b0, 5'd4}};
        tbl[1]  = '{16'hF0F0, 16'hFF00, OP_OR,    '{16'hFFF0, 1'b0, 1'b1, 1'b0, 5'd12}};
        tbl[2]  = '{16'hF0F0, 16'hFF00, OP_XOR,   '{16'h0FF0, 1'b0, 1'b0, 1'b0, 5'd8}};
        tbl[3]  = '{16'hF0F0, 16'hFF00, OP_NAND,  '{16'h0FFF, 1'b0, 1'b0, 1'b0, 5'd12}};
        tbl[4]  = '{16'hF0F0, 16'hFF00, OP_NOR,   '{16'h000F, 1'b0, 1'b0, 1'b0, 5'd4}};
        tbl[5]  = '{16'hF0F0, 16'hFF00, OP_XNOR,  '{16'hF00F, 1'b0, 1'b1, 1'b0, 5'd8}};
        tbl[6]  = '{16'hF0F0, 16'hFF00, OP_NOTA,  '{16'h0F0F, 1'b0, 1'b0, 1'b0, 5'd8}};
        tbl[7]  = '{16'hF0F0, 16'hFF00, OP_PASSB, '{16'hFF00, 1'b0, 1'b1, 1'b0, 5'd8}};
        tbl[8]  = '{16'h1234, 16'h0000, OP_AND,   '{16'h0000, 1'b1, 1'b0, 1'b0, 5'd0}};
        tbl[9]  = '{16'h0007, 16'h0000, OP_XOR,   '{16'h0007, 1'b0, 1'b0, 1'b1, 5'd3}};
        tbl[10] = '{16'hAAAA, 16'h5555, OP_PASSB, '{16'h5555, 1'b0, 1'b0, 1'b0, 5'd8}};

        bp[0] = '{16'h8001, 16'h0000, OP_OR,   mk(16'h8001)};
        bp[1] = '{16'h00FF, 16'h0F0F, OP_AND,  mk(16'h000F)};
        bp[2] = '{16'h0000, 16'h0000, OP_NOR,  mk(16'hFFFF)};
        bp[3] = '{16'hC3C3, 16'h0000, OP_NOTA, mk(16'h3C3C)};

        // Outputs while reset is held.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_s", 32'(out_s), 32'd0);
        chk("rst_flags", {29'd0, out_zero, out_msb, out_parity}, 32'd0);
        #4 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_out_s", 32'(out_s), 32'd0);
        @(posedge clk);
        #1;

        // Latency: accepted at P1, out_valid after P2.
        send(tbl[8].a, tbl[8].b, tbl[8].op, tbl[8].e);
        idle();
        @(negedge clk);
        chk("latency_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_cycle2_valid", 32'(out_valid), 32'd1);
        chk("zero_case_flag", 32'(out_zero), 32'd1);
        @(posedge clk);
        #1;
        drain("latency_drain");

        // Back-to-back stream of the whole table; no stalls expected.
        stall_cnt = 0;
        for (int i = 0; i < 11; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].e);
        idle();
        chk("stream_stalls", 32'(stall_cnt), 32'd0);
        drain("stream_drain");

        // Bubble: out_valid drops, out_s keeps last value (0x5555).
        @(negedge clk);
        chk("bubble_valid", 32'(out_valid), 32'd0);
        chk("bubble_out_s", 32'(out_s), 32'h5555);
        @(posedge clk);
        #1;

        // Backpressure: offer beats for 4 cycles with out_ready low.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_a = bp[acc].a;
            in_b = bp[acc].b;
            in_op = bp[acc].op;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(bp[acc].e);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_stall_hold", 32'(out_s), 32'(bp[0].e.s));
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            in_valid = 1'b1;
            in_a = bp[acc].a;
            in_b = bp[acc].b;
            in_op = bp[acc].op;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(bp[acc].e);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        idle();
        chk("bp_all_accepted", 32'(acc), 32'd4);
        drain("bp_drain");

        // Reset with two beats in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            in_a = bp[c].a;
            in_b = bp[c].b;
            in_op = bp[c].op;
            @(posedge clk);
            #1;
        end
        idle();
        #2;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_s", 32'(out_s), 32'd0);
        chk("async_rst_flags", {29'd0, out_zero, out_msb, out_parity}, 32'd0);
        chk("async_rst_popcnt", 32'(out_popcnt), 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        chk("no_beat_after_reset", 32'(saw), 32'd0);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // WIDTH=8 instance: XOR 0x01 ^ 0x00.
        v8 = 1'b1;
        a8 = 8'h01;
        b8 = 8'h00;
        op8 = OP_XOR;
        @(negedge clk);
        chk("w8_in_ready", 32'(rdy8), 32'd1);
        @(posedge clk);
        #1;
        v8 = 1'b0;
        @(negedge clk);
        chk("w8_latency1", 32'(ov8), 32'd0);
        @(negedge clk);
        chk("w8_valid", 32'(ov8), 32'd1);
        chk("w8_out_s", 32'(s8), 32'h01);
        chk("w8_parity", 32'(p8), 32'd1);
        chk("w8_msb", 32'(m8), 32'd0);
        chk("w8_zero", 32'(z8), 32'd0);
`ifdef LOGIC_UNIT_POPCOUNT_EN
        chk("w8_popcnt", 32'(pc8), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

endmodule
